// File: rtl/envelope_gen.sv
// ADSR envelope generator: prescaled step timing, five-state envelope FSM, and
// a registered multiplier that scales an offset-binary sample by the envelope.
module envelope_gen #(
  parameter int WAVE_DEPTH = 8,
  parameter int PRESCALE   = 256
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Gate,
  input  logic [7:0]            AttackRate,
  input  logic [7:0]            DecayRate,
  input  logic [7:0]            SustainLevel,
  input  logic [7:0]            ReleaseRate,
  input  logic [WAVE_DEPTH-1:0] WaveIn,
  output logic [WAVE_DEPTH-1:0] WaveOut,
  output logic [7:0]            Envelope,
  output logic                  Active
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_DECAY,
    ST_SUSTAIN,
    ST_RELEASE
  } state_t;

  localparam logic [15:0]           PRE_MAX = 16'(PRESCALE - 1);
  localparam logic [WAVE_DEPTH:0]   MID_EXT = (WAVE_DEPTH + 1)'(2 ** (WAVE_DEPTH - 1));
  localparam logic [WAVE_DEPTH-1:0] MID     = WAVE_DEPTH'(2 ** (WAVE_DEPTH - 1));

  state_t                  state_q, state_d;
  logic [7:0]              env_q, env_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    gate_q, gate_d;
  logic                    active_q, active_d;
  logic [WAVE_DEPTH-1:0]   wave_q, wave_d;

  logic                    tick;
  logic                    rise, fall;
  logic [8:0]              att_sum, dec_diff, rel_diff;
  logic [7:0]              att_val, dec_val, rel_val;
  logic [WAVE_DEPTH:0]     samp;
  logic signed [WAVE_DEPTH+9:0] samp_ext, env_ext, prod;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      env_q    <= 8'd0;
      cnt_q    <= 16'd0;
      gate_q   <= 1'b0;
      active_q <= 1'b0;
      wave_q   <= MID;
    end else begin
      state_q  <= state_d;
      env_q    <= env_d;
      cnt_q    <= cnt_d;
      gate_q   <= gate_d;
      active_q <= active_d;
      wave_q   <= wave_d;
    end
  end

  always_comb begin
    tick   = (cnt_q == PRE_MAX);
    cnt_d  = tick ? 16'd0 : cnt_q + 16'd1;
    gate_d = Gate;
    rise   = Gate & ~gate_q;
    fall   = ~Gate & gate_q;

    // Step targets are 9-bit so overflow/underflow shows up in bit 8.
    att_sum  = {1'b0, env_q} + {1'b0, AttackRate};
    dec_diff = {1'b0, env_q} - {1'b0, DecayRate};
    rel_diff = {1'b0, env_q} - {1'b0, ReleaseRate};
    att_val  = (AttackRate == 8'd0 || att_sum[8]) ? 8'hFF : att_sum[7:0];
    dec_val  = (DecayRate == 8'd0 || dec_diff[8] || dec_diff[7:0] < SustainLevel)
               ? SustainLevel : dec_diff[7:0];
    rel_val  = (ReleaseRate == 8'd0 || rel_diff[8]) ? 8'd0 : rel_diff[7:0];
  end

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    // Gate-driven transitions take priority and swallow a coincident tick.
    case (state_q)
      ST_IDLE: begin
        env_d = 8'd0;
        if (Gate) state_d = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (fall) begin
          state_d = ST_RELEASE;
        end else if (tick) begin
          env_d = att_val;
          if (att_val == 8'hFF) state_d = ST_DECAY;
        end
      end
      ST_DECAY: begin
        if (fall) begin
          state_d = ST_RELEASE;
        end else if (tick) begin
          env_d = dec_val;
          if (dec_val == SustainLevel) state_d = ST_SUSTAIN;
        end
      end
      ST_SUSTAIN: begin
        if (fall) state_d = ST_RELEASE;
        else      env_d   = SustainLevel;
      end
      ST_RELEASE: begin
        if (rise) begin
          state_d = ST_ATTACK;
        end else if (tick) begin
          env_d = rel_val;
          if (rel_val == 8'd0) state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        env_d   = 8'd0;
      end
    endcase
    active_d = (state_d != ST_IDLE);
  end

  // Signed sample times unsigned envelope, floor-divided by 256, re-biased.
  always_comb begin
    samp     = {1'b0, WaveIn} - MID_EXT;
    samp_ext = {{9{samp[WAVE_DEPTH]}}, samp};
    env_ext  = {{(WAVE_DEPTH + 2){1'b0}}, env_q};
    prod     = samp_ext * env_ext;
    wave_d   = WAVE_DEPTH'(prod >>> 8) + MID;
  end

  assign WaveOut  = wave_q;
  assign Envelope = env_q;
  assign Active   = active_q;

endmodule

// File: tb/tb_envelope_gen.sv
// Scoreboard bench for envelope_gen at WAVE_DEPTH=8, PRESCALE=4: expected
// envelope steps and scaled samples are queued as stimulus is applied.
module tb_envelope_gen;
  localparam int WD = 8;
  localparam int PS = 4;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Gate = 1'b0;
  logic [7:0]    AttackRate = 8'd0;
  logic [7:0]    DecayRate = 8'd0;
  logic [7:0]    SustainLevel = 8'd0;
  logic [7:0]    ReleaseRate = 8'd0;
  logic [WD-1:0] WaveIn = 8'd128;
  logic [WD-1:0] WaveOut;
  logic [7:0]    Envelope;
  logic          Active;

  int checks = 0;
  int errors = 0;
  logic [7:0] env_exp_q[$];
  logic [7:0] wave_exp_q[$];

  envelope_gen #(.WAVE_DEPTH(WD), .PRESCALE(PS)) dut (
    .Clock(Clock), .Reset(Reset), .Gate(Gate),
    .AttackRate(AttackRate), .DecayRate(DecayRate),
    .SustainLevel(SustainLevel), .ReleaseRate(ReleaseRate),
    .WaveIn(WaveIn), .WaveOut(WaveOut), .Envelope(Envelope), .Active(Active)
  );

  always #5 Clock = ~Clock;

  function automatic logic [7:0] wave_model(input int w, input int e);
    int p;
    p = ((w - 128) * e) >>> 8;
    return 8'((p + 128) & 255);
  endfunction

  task automatic wait_env_change(output int cycles, output bit timed_out);
    logic [7:0] old;
    old = Envelope;
    cycles = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      cycles++;
      if (Envelope !== old) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic next_env(output logic [7:0] act, output logic [7:0] exp, output bit to);
    int cyc;
    exp = env_exp_q.pop_front();
    wait_env_change(cyc, to);
    act = Envelope;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #1 Reset = 1'b0;
    #1;
    checks++;
    if (Envelope !== 8'd0) begin errors++; $display("FAIL reset_env got %0d want 0", Envelope); end
    else $display("ok reset_env %0d", Envelope);
    checks++;
    if (WaveOut !== 8'd128) begin errors++; $display("FAIL reset_wave got %0d want 128", WaveOut); end
    else $display("ok reset_wave %0d", WaveOut);
    checks++;
    if (Active !== 1'b0) begin errors++; $display("FAIL reset_active got %0b want 0", Active); end
    else $display("ok reset_active %0b", Active);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_attack_decay();
    logic [7:0] a, e;
    bit to;
    AttackRate = 8'd64; DecayRate = 8'd100; SustainLevel = 8'd50; ReleaseRate = 8'd30;
    Gate = 1'b1;
    @(negedge Clock);
    checks++;
    if (Active !== 1'b1 || Envelope !== 8'd0) begin
      errors++; $display("FAIL attack_entry active=%0b env=%0d want 1/0", Active, Envelope);
    end else $display("ok attack_entry");
    env_exp_q = '{8'd64, 8'd128, 8'd192, 8'd255, 8'd155, 8'd55, 8'd50};
    while (env_exp_q.size() > 0) begin
      next_env(a, e, to);
      checks++;
      if (to || a !== e) begin errors++; $display("FAIL attack_decay_step got %0d want %0d timeout=%0b", a, e, to); end
      else $display("ok attack_decay_step %0d", a);
    end
    // The last step landed on a tick edge; 12 clocks later is also a tick edge.
    repeat (12) @(negedge Clock);
    checks++;
    if (Envelope !== 8'd50) begin errors++; $display("FAIL sustain_hold got %0d want 50", Envelope); end
    else $display("ok sustain_hold %0d", Envelope);
    SustainLevel = 8'd80;
    @(negedge Clock);
    checks++;
    if (Envelope !== 8'd80) begin errors++; $display("FAIL sustain_track got %0d want 80", Envelope); end
    else $display("ok sustain_track %0d", Envelope);
  endtask

  task automatic test_release();
    logic [7:0] a, e;
    bit to;
    Gate = 1'b0;
    @(negedge Clock);
    checks++;
    if (Envelope !== 8'd80 || Active !== 1'b1) begin
      errors++; $display("FAIL release_entry env=%0d active=%0b want 80/1", Envelope, Active);
    end else $display("ok release_entry");
    env_exp_q = '{8'd50, 8'd20, 8'd0};
    while (env_exp_q.size() > 0) begin
      next_env(a, e, to);
      checks++;
      if (to || a !== e) begin errors++; $display("FAIL release_step got %0d want %0d timeout=%0b", a, e, to); end
      else $display("ok release_step %0d", a);
    end
    checks++;
    if (Active !== 1'b0) begin errors++; $display("FAIL release_idle active got %0b want 0", Active); end
    else $display("ok release_idle");
  endtask

  task automatic test_retrigger();
    logic [7:0] a, e;
    bit to;
    AttackRate = 8'd100; DecayRate = 8'd100; SustainLevel = 8'd80; ReleaseRate = 8'd30;
    Gate = 1'b1;
    env_exp_q = '{8'd100, 8'd200, 8'd255, 8'd155, 8'd80};
    while (env_exp_q.size() > 0) begin
      next_env(a, e, to);
      checks++;
      if (to || a !== e) begin errors++; $display("FAIL retrig_setup got %0d want %0d timeout=%0b", a, e, to); end
      else $display("ok retrig_setup %0d", a);
    end
    Gate = 1'b0;
    env_exp_q.push_back(8'd50);
    next_env(a, e, to);
    checks++;
    if (to || a !== e) begin errors++; $display("FAIL retrig_release got %0d want %0d timeout=%0b", a, e, to); end
    else $display("ok retrig_release %0d", a);
    Gate = 1'b1;
    @(negedge Clock);
    checks++;
    if (Envelope !== 8'd50 || Active !== 1'b1) begin
      errors++; $display("FAIL retrig_entry env=%0d active=%0b want 50/1", Envelope, Active);
    end else $display("ok retrig_entry");
    env_exp_q = '{8'd150, 8'd250, 8'd255, 8'd155, 8'd80};
    while (env_exp_q.size() > 0) begin
      next_env(a, e, to);
      checks++;
      if (to || a !== e) begin errors++; $display("FAIL retrig_step got %0d want %0d timeout=%0b", a, e, to); end
      else $display("ok retrig_step %0d", a);
    end
  endtask

  task automatic test_scaling();
    int w255[4] = '{255, 0, 200, 128};
    int w80[3]  = '{255, 0, 100};
    int w0[3]   = '{37, 255, 0};
    logic [7:0] a, e;
    bit to;
    SustainLevel = 8'd255;
    @(negedge Clock);
    checks++;
    if (Envelope !== 8'd255) begin errors++; $display("FAIL scale_env255 got %0d want 255", Envelope); end
    foreach (w255[i]) begin
      WaveIn = 8'(w255[i]);
      wave_exp_q.push_back(wave_model(w255[i], 255));
      @(negedge Clock);
      e = wave_exp_q.pop_front();
      checks++;
      if (WaveOut !== e) begin errors++; $display("FAIL scale_e255 in=%0d got %0d want %0d", w255[i], WaveOut, e); end
      else $display("ok scale_e255 in=%0d out=%0d", w255[i], WaveOut);
    end
    SustainLevel = 8'd80;
    @(negedge Clock);
    checks++;
    if (Envelope !== 8'd80) begin errors++; $display("FAIL scale_env80 got %0d want 80", Envelope); end
    foreach (w80[i]) begin
      WaveIn = 8'(w80[i]);
      wave_exp_q.push_back(wave_model(w80[i], 80));
      @(negedge Clock);
      e = wave_exp_q.pop_front();
      checks++;
      if (WaveOut !== e) begin errors++; $display("FAIL scale_e80 in=%0d got %0d want %0d", w80[i], WaveOut, e); end
      else $display("ok scale_e80 in=%0d out=%0d", w80[i], WaveOut);
    end
    Gate = 1'b0;
    ReleaseRate = 8'd0;
    env_exp_q.push_back(8'd0);
    next_env(a, e, to);
    checks++;
    if (to || a !== e || Active !== 1'b0) begin
      errors++; $display("FAIL release_rate0 got %0d active=%0b want 0/0 timeout=%0b", a, Active, to);
    end else $display("ok release_rate0");
    foreach (w0[i]) begin
      WaveIn = 8'(w0[i]);
      wave_exp_q.push_back(8'd128);
      @(negedge Clock);
      e = wave_exp_q.pop_front();
      checks++;
      if (WaveOut !== e) begin errors++; $display("FAIL scale_e0 in=%0d got %0d want %0d", w0[i], WaveOut, e); end
      else $display("ok scale_e0 in=%0d out=%0d", w0[i], WaveOut);
    end
  endtask

  task automatic test_gate_tick();
    logic [7:0] a, e;
    bit to;
    int cyc;
    AttackRate = 8'd10; ReleaseRate = 8'd0;
    Gate = 1'b1;
    env_exp_q.push_back(8'd10);
    next_env(a, e, to);
    checks++;
    if (to || a !== e) begin errors++; $display("FAIL gt_attack got %0d want %0d timeout=%0b", a, e, to); end
    else $display("ok gt_attack %0d", a);
    // Three clocks after a tick edge the next edge is a tick again.
    repeat (3) @(negedge Clock);
    Gate = 1'b0;
    @(negedge Clock);
    checks++;
    if (Envelope !== 8'd10) begin errors++; $display("FAIL gt_hold got %0d want 10", Envelope); end
    else $display("ok gt_hold %0d", Envelope);
    wait_env_change(cyc, to);
    checks++;
    if (to || Envelope !== 8'd0 || cyc != PS) begin
      errors++; $display("FAIL gt_consumed env=%0d cycles=%0d want 0 after %0d timeout=%0b", Envelope, cyc, PS, to);
    end else $display("ok gt_consumed cycles=%0d", cyc);
  endtask

  task automatic test_rate_zero();
    logic [7:0] a, e;
    bit to;
    AttackRate = 8'd0; DecayRate = 8'd0; SustainLevel = 8'd40;
    Gate = 1'b1;
    env_exp_q = '{8'd255, 8'd40};
    while (env_exp_q.size() > 0) begin
      next_env(a, e, to);
      checks++;
      if (to || a !== e) begin errors++; $display("FAIL rate0_step got %0d want %0d timeout=%0b", a, e, to); end
      else $display("ok rate0_step %0d", a);
    end
    Gate = 1'b0; ReleaseRate = 8'd255;
    env_exp_q.push_back(8'd0);
    next_env(a, e, to);
    checks++;
    if (to || a !== e || Active !== 1'b0) begin
      errors++; $display("FAIL rate0_release got %0d active=%0b want 0/0", a, Active);
    end else $display("ok rate0_release");
  endtask

  task automatic test_back_to_back();
    Gate = 1'b1;
    @(negedge Clock);
    checks++;
    if (Active !== 1'b1) begin errors++; $display("FAIL pulse_attack active got %0b want 1", Active); end
    else $display("ok pulse_attack");
    Gate = 1'b0;
    @(negedge Clock);
    checks++;
    if (Active !== 1'b1 || Envelope !== 8'd0) begin
      errors++; $display("FAIL pulse_release active=%0b env=%0d want 1/0", Active, Envelope);
    end else $display("ok pulse_release");
    for (int i = 0; i < 10; i++) begin
      if (Active === 1'b0) break;
      @(negedge Clock);
    end
    checks++;
    if (Active !== 1'b0 || Envelope !== 8'd0) begin
      errors++; $display("FAIL pulse_idle active=%0b env=%0d want 0/0", Active, Envelope);
    end else $display("ok pulse_idle");
  endtask

  task automatic test_reset_mid_note();
    logic [7:0] a, e;
    bit to;
    AttackRate = 8'd64; WaveIn = 8'd255;
    Gate = 1'b1;
    env_exp_q.push_back(8'd64);
    next_env(a, e, to);
    checks++;
    if (to || a !== e) begin errors++; $display("FAIL rst_attack got %0d want %0d timeout=%0b", a, e, to); end
    wave_exp_q.push_back(wave_model(255, 64));
    @(negedge Clock);
    e = wave_exp_q.pop_front();
    checks++;
    if (WaveOut !== e) begin errors++; $display("FAIL rst_prewave got %0d want %0d", WaveOut, e); end
    else $display("ok rst_prewave %0d", WaveOut);
    #2 Reset = 1'b0;
    #1;
    checks++;
    if (Envelope !== 8'd0 || WaveOut !== 8'd128 || Active !== 1'b0) begin
      errors++; $display("FAIL rst_async env=%0d wave=%0d active=%0b want 0/128/0", Envelope, WaveOut, Active);
    end else $display("ok rst_async");
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    checks++;
    if (Active !== 1'b1) begin errors++; $display("FAIL rst_restart active got %0b want 1", Active); end
    else $display("ok rst_restart");
    env_exp_q.push_back(8'd64);
    next_env(a, e, to);
    checks++;
    if (to || a !== e) begin errors++; $display("FAIL rst_reattack got %0d want %0d timeout=%0b", a, e, to); end
    else $display("ok rst_reattack %0d", a);
    Gate = 1'b0;
  endtask

  initial begin
    test_reset();
    test_attack_decay();
    test_release();
    test_retrigger();
    test_scaling();
    test_gate_tick();
    test_rate_zero();
    test_back_to_back();
    test_reset_mid_note();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
